// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mdu_sequencer
// Purpose  : E-stage multiply/divide sequencer. Computes at issue, models the
//            fixed MDU latency with a down-counter, commits to HI/LO at the end.
//            Optional abort input enabled by defining MDU_CANCEL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [2:0]  operation,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        start,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] c_op_mult  = 3'd1;
    localparam logic [2:0] c_op_multu = 3'd2;
    localparam logic [2:0] c_op_div   = 3'd3;
    localparam logic [2:0] c_op_divu  = 3'd4;
    localparam logic [2:0] c_op_mthi  = 3'd5;
    localparam logic [2:0] c_op_mtlo  = 3'd6;

    localparam logic [7:0] c_mult_last = 8'(MULT_CYCLES - 1);
    localparam logic [7:0] c_div_last  = 8'(DIV_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_count;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_dz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_cancel;
    logic        w_idle;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_signed;
    logic        w_commit;
    logic        w_div_zero;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

`ifdef MDU_CANCEL_EN
    assign w_cancel = cancel;
`else
    assign w_cancel = 1'b0;
`endif

    assign w_idle   = (r_state == S_IDLE);
    assign w_is_mul = (operation == c_op_mult) || (operation == c_op_multu);
    assign w_is_div = (operation == c_op_div)  || (operation == c_op_divu);
    assign w_signed = (operation == c_op_mult) || (operation == c_op_div);
    assign start    = w_idle && (w_is_mul || w_is_div) && !w_cancel;

    // Low 64 bits of the product of the 64-bit extended operands are exact for both signednesses.
    assign w_mul_a = {{32{w_signed & operand1[31]}}, operand1};
    assign w_mul_b = {{32{w_signed & operand2[31]}}, operand2};
    assign w_prod  = w_mul_a * w_mul_b;

    // Signed division runs on magnitudes, so 0x80000000 / -1 needs no special case.
    assign w_neg_a    = w_signed & operand1[31];
    assign w_neg_b    = w_signed & operand2[31];
    assign w_mag_a    = w_neg_a ? (~operand1 + 32'd1) : operand1;
    assign w_mag_b    = w_neg_b ? (~operand2 + 32'd1) : operand2;
    assign w_div_zero = (operand2 == 32'd0);
    assign w_divisor  = w_div_zero ? 32'd1 : w_mag_b;
    assign w_q_mag    = w_mag_a / w_divisor;
    assign w_r_mag    = w_mag_a % w_divisor;
    assign w_quot     = (w_neg_a ^ w_neg_b) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem      = w_neg_a ? (~w_r_mag + 32'd1) : w_r_mag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_cancel) begin
                    w_next_state = S_IDLE;
                end else if (r_count == 8'd0) begin
                    w_next_state = S_IDLE;
                    w_commit     = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count   <= 8'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_dz <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (start) begin
                r_pend_hi <= w_is_mul ? w_prod[63:32] : w_rem;
                r_pend_lo <= w_is_mul ? w_prod[31:0]  : w_quot;
                r_pend_dz <= w_is_div && w_div_zero;
                r_count   <= w_is_mul ? c_mult_last : c_div_last;
            end else if ((r_state == S_BUSY) && (r_count != 8'd0)) begin
                r_count <= r_count - 8'd1;
            end
            if (w_commit) begin
                if (!r_pend_dz) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
            end else if (w_idle && !w_cancel) begin
                if (operation == c_op_mthi) begin
                    r_hi <= operand1;
                end
                if (operation == c_op_mtlo) begin
                    r_lo <= operand1;
                end
            end
        end
    end

    assign HI   = r_hi;
    assign LO   = r_lo;
    assign busy = (r_state == S_BUSY);
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_sequencer
// Purpose  : Self-checking bench for mdu_sequencer: directed and random
//            operations checked against a 64-bit arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_sequencer;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk;
    logic        reset;
    logic        cancel;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [2:0]  operation;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        start;
    logic        busy;
    logic        done;

    int          total;
    int          bad;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mdu_sequencer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef MDU_CANCEL_EN
        .cancel    (cancel),
`endif
        .operand1  (operand1),
        .operand2  (operand2),
        .operation (operation),
        .HI        (HI),
        .LO        (LO),
        .start     (start),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one operation on HI/LO, from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin
                sp = sa * sb;
                exp_hi = sp[63:32];
                exp_lo = sp[31:0];
            end
            3'd2: begin
                up = {32'd0, a} * {32'd0, b};
                exp_hi = up[63:32];
                exp_lo = up[31:0];
            end
            3'd3: if (b != 0) begin
                sq = sa / sb;
                sr = sa % sb;
                exp_lo = sq[31:0];
                exp_hi = sr[31:0];
            end
            3'd4: if (b != 0) begin
                exp_lo = a / b;
                exp_hi = a % b;
            end
            3'd5: exp_hi = a;
            3'd6: exp_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] old_hi, old_lo;
        logic        st;
        int          n, cyc;
        old_hi = exp_hi;
        old_lo = exp_lo;
        st = (op >= 3'd1) && (op <= 3'd4);
        n  = (op == 3'd1 || op == 3'd2) ? MULT_CYCLES : DIV_CYCLES;
        model(op, a, b);
        operation = op;
        operand1  = a;
        operand2  = b;
        #1;
        chk("start", 32'(start), 32'(st));
        @(posedge clk); #1;
        operation = 3'd0;
        operand1  = $urandom;
        operand2  = $urandom;
        chk("done_after_issue", 32'(done), 32'd0);
        if (st) begin
            cyc = 0;
            while (busy === 1'b1 && cyc < 300) begin
                chk("hold_hi", HI, old_hi);
                chk("hold_lo", LO, old_lo);
                chk("done_busy", 32'(done), 32'd0);
                operation = 3'($urandom_range(0, 7));
                operand1  = $urandom;
                @(posedge clk); #1;
                cyc++;
            end
            operation = 3'd0;
            chk("busy_cycles", 32'(cyc), 32'(n));
            chk("done_pulse", 32'(done), 32'd1);
        end else begin
            chk("busy_idle", 32'(busy), 32'd0);
        end
        chk("hi", HI, exp_hi);
        chk("lo", LO, exp_lo);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          k;
        total     = 0;
        bad       = 0;
        exp_hi    = 32'd0;
        exp_lo    = 32'd0;
        reset     = 1'b0;
        cancel    = 1'b0;
        operation = 3'd0;
        operand1  = 32'd0;
        operand2  = 32'd0;

        #12;
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        run_op(3'd1, 32'd3, 32'hFFFF_FFFE);
        chk("mult_hi_lit", HI, 32'hFFFF_FFFF);
        chk("mult_lo_lit", LO, 32'hFFFF_FFFA);
        run_op(3'd4, 32'd7, 32'd2);
        chk("divu_lo_lit", LO, 32'd3);
        chk("divu_hi_lit", HI, 32'd1);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        chk("div_lo_lit", LO, 32'hFFFF_FFFD);
        chk("div_hi_lit", HI, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h1234_5678, 32'd0);
        run_op(3'd5, 32'hCAFE_F00D, 32'd0);
        chk("mt_lo_lit", LO, 32'h1234_5678);
        chk("mt_hi_lit", HI, 32'hCAFE_F00D);
        run_op(3'd5, 32'h0000_AAAA, 32'd0);
        run_op(3'd6, 32'h0000_5555, 32'd0);
        run_op(3'd3, 32'd1234, 32'd0);
        chk("dz_hi_lit", HI, 32'h0000_AAAA);
        chk("dz_lo_lit", LO, 32'h0000_5555);
        run_op(3'd4, 32'hFFFF_0000, 32'd0);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("ovf_lo_lit", LO, 32'h8000_0000);
        chk("ovf_hi_lit", HI, 32'd0);
        run_op(3'd7, 32'hDEAD_BEEF, 32'd1);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd3, 32'h8000_0001, 32'hFFFF_FFF0);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            k   = $urandom_range(0, 5);
            rb  = (k == 0) ? 32'd0 : (k == 1) ? 32'($urandom_range(1, 9)) : $urandom;
            run_op(rop, ra, rb);
        end

        // Asynchronous reset during the third busy cycle of a MULTU.
        operation = 3'd2;
        operand1  = 32'h0001_0000;
        operand2  = 32'h0001_0000;
        @(posedge clk); #1;
        operation = 3'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_hi", HI, 32'd0);
        chk("arst_lo", LO, 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        run_op(3'd5, 32'd1, 32'd0);
        chk("post_rst_hi", HI, 32'd1);

`ifdef MDU_CANCEL_EN
        run_op(3'd5, 32'd7, 32'd0);
        run_op(3'd6, 32'd7, 32'd0);
        operation = 3'd1;
        operand1  = 32'd4;
        operand2  = 32'd4;
        #1;
        chk("cx_start", 32'(start), 32'd1);
        @(posedge clk); #1;
        operation = 3'd0;
        @(posedge clk); #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cx_busy", 32'(busy), 32'd0);
        chk("cx_done", 32'(done), 32'd0);
        chk("cx_hi", HI, 32'd7);
        chk("cx_lo", LO, 32'd7);
        @(posedge clk); #1;
        chk("cx_done2", 32'(done), 32'd0);
        operation = 3'd1;
        cancel    = 1'b1;
        #1;
        chk("cx_idle_start", 32'(start), 32'd0);
        operation = 3'd5;
        operand1  = 32'hDEAD_0001;
        @(posedge clk); #1;
        chk("cx_mthi_hi", HI, 32'd7);
        chk("cx_mthi_busy", 32'(busy), 32'd0);
        cancel    = 1'b0;
        operation = 3'd0;
`endif

        @(posedge clk); #1;
        chk("final_done", 32'(done), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
